// File: rtl/ne_adder3_layer_sched.sv
// rtl/ne_adder3_layer_sched.sv - layer/iteration sequencer for the pipelined 3-input adder array
//
// Purpose: issues one block-column operand fetch per cycle for each layer,
// carries {valid, layer, col} tags alongside the adder pipeline, and emits
// write-back strobes aligned with the adder output. The pipeline is drained
// between layers, iterations repeat up to max_iter, and a syndrome pass at
// the end of an iteration stops the frame early.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, max_iter     frame start (sampled in IDLE) and iteration limit (0 means 1)
//   hold                suspends operand issue; in-flight tags keep draining
//   syndrome_ok         parity check result, sampled at iteration end
//   rd_en/rd_layer/rd_col   operand fetch strobe and address
//   wr_en/wr_layer/wr_col   write-back strobe and address, 1+LAT cycles after the fetch
//   iter                current iteration index
//   busy, done, early   not-idle flag, one-cycle completion pulse, stopped-by-syndrome flag

module ne_adder3_layer_sched #(
    parameter int LAT    = 2,
    parameter int NCOL   = 24,
    parameter int NLAYER = 8,
    parameter int CW     = 5,
    parameter int LW     = 3,
    parameter int IW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [IW-1:0] max_iter,
    input  logic          hold,
    input  logic          syndrome_ok,
    output logic          rd_en,
    output logic [LW-1:0] rd_layer,
    output logic [CW-1:0] rd_col,
    output logic          wr_en,
    output logic [LW-1:0] wr_layer,
    output logic [CW-1:0] wr_col,
    output logic [IW-1:0] iter,
    output logic          busy,
    output logic          done,
    output logic          early
);

    localparam int DEPTH = 1 + LAT;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_LWAIT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [IW-1:0]   r_max_iter;
    logic [IW-1:0]   r_iter;
    logic [LW-1:0]   r_layer;
    logic [CW-1:0]   r_col;
    logic            r_early;

    // Tag pipe: index 0 is the newest entry, DEPTH-1 drives the write-back.
    logic [DEPTH-1:0] r_pv;
    logic [LW-1:0]    r_pl [DEPTH];
    logic [CW-1:0]    r_pc [DEPTH];

    logic            w_rd_en;
    logic            w_start_acc;
    logic            w_col_adv;
    logic            w_layer_adv;
    logic            w_iter_adv;
    logic            w_set_early;
    logic            w_drain_soon;
    logic            w_drained;
    logic            w_last_col;
    logic            w_last_layer;
    logic            w_last_iter;

    // A new layer may start fetching once only the output stage is still
    // valid: that final write lands at the end of this cycle, before the
    // next layer's first fetch can read it back.
    assign w_drain_soon = ~|r_pv[DEPTH-2:0];
    // The syndrome must see every write of the iteration, so iteration end
    // waits until the whole pipe is empty (one cycle later).
    assign w_drained    = ~|r_pv;

    assign w_last_col   = (r_col == CW'(NCOL - 1));
    assign w_last_layer = (r_layer == LW'(NLAYER - 1));
    // eff_max = max(max_iter, 1)
    assign w_last_iter  = (r_max_iter == '0) ? (r_iter == '0)
                                             : (r_iter == r_max_iter - IW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_start_acc = 1'b0;
        w_col_adv   = 1'b0;
        w_layer_adv = 1'b0;
        w_iter_adv  = 1'b0;
        w_set_early = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!hold) begin
                    w_rd_en   = 1'b1;
                    w_col_adv = 1'b1;
                    if (w_last_col) begin
                        w_state_nxt = S_LWAIT;
                    end
                end
            end
            S_LWAIT: begin
                if (!w_last_layer) begin
                    if (w_drain_soon) begin
                        w_layer_adv = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end else if (w_drained) begin
                    if (syndrome_ok) begin
                        w_set_early = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (w_last_iter) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_iter_adv  = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max_iter <= '0;
            r_iter     <= '0;
            r_layer    <= '0;
            r_col      <= '0;
            r_early    <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_max_iter <= max_iter;
                r_iter     <= '0;
                r_layer    <= '0;
                r_col      <= '0;
                r_early    <= 1'b0;
            end
            if (w_col_adv) begin
                r_col <= w_last_col ? '0 : r_col + CW'(1);
            end
            if (w_layer_adv) begin
                r_layer <= r_layer + LW'(1);
            end
            if (w_iter_adv) begin
                r_iter  <= r_iter + IW'(1);
                r_layer <= '0;
            end
            if (w_set_early) begin
                r_early <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pl[i] <= '0;
                r_pc[i] <= '0;
            end
        end else begin
            r_pv    <= {r_pv[DEPTH-2:0], w_rd_en};
            r_pl[0] <= r_layer;
            r_pc[0] <= r_col;
            for (int i = 1; i < DEPTH; i++) begin
                r_pl[i] <= r_pl[i-1];
                r_pc[i] <= r_pc[i-1];
            end
        end
    end

    assign rd_en    = w_rd_en;
    assign rd_layer = r_layer;
    assign rd_col   = r_col;
    assign wr_en    = r_pv[DEPTH-1];
    assign wr_layer = r_pl[DEPTH-1];
    assign wr_col   = r_pc[DEPTH-1];
    assign iter     = r_iter;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign early    = r_early;

endmodule

// File: tb/tb_ne_adder3_layer_sched.sv
// tb/tb_ne_adder3_layer_sched.sv - self-checking bench for ne_adder3_layer_sched
module tb_ne_adder3_layer_sched;
    localparam int LAT    = 2;
    localparam int NCOL   = 4;
    localparam int NLAYER = 2;
    localparam int CW     = 5;
    localparam int LW     = 3;
    localparam int IW     = 5;
    localparam int NC     = 256;
    localparam int TW     = 1 + LW + CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] max_iter = '0;
    logic          hold = 1'b0;
    logic          syndrome_ok = 1'b0;
    logic          rd_en, wr_en, busy, done, early;
    logic [LW-1:0] rd_layer, wr_layer;
    logic [CW-1:0] rd_col, wr_col;
    logic [IW-1:0] iter;

    int n_chk = 0;
    int n_err = 0;

    bit            hold_at [NC];
    bit            synd_at [NC];
    logic [TW-1:0] exp_rd [NC];
    logic [TW-1:0] exp_wr [NC];
    int            m_done;
    int            m_iter;
    int            m_early;

    typedef struct {
        int mi;
        int hold_lo;
        int hold_hi;
        int synd_from;
        bit busy_start;
        int exp_done;
        int exp_early;
        int exp_iter;
        int exp_rd;
    } vec_t;

    ne_adder3_layer_sched #(
        .LAT(LAT), .NCOL(NCOL), .NLAYER(NLAYER), .CW(CW), .LW(LW), .IW(IW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .max_iter(max_iter),
        .hold(hold), .syndrome_ok(syndrome_ok),
        .rd_en(rd_en), .rd_layer(rd_layer), .rd_col(rd_col),
        .wr_en(wr_en), .wr_layer(wr_layer), .wr_col(wr_col),
        .iter(iter), .busy(busy), .done(done), .early(early)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_stim(input int hlo, input int hhi, input int sf);
        for (int c = 0; c < NC; c++) begin
            hold_at[c] = (c >= hlo) && (c <= hhi);
            synd_at[c] = (sf >= 0) && (c >= sf);
        end
    endtask

    // Schedule arithmetic: fetches back-to-back except for hold cycles, the
    // next layer's first fetch 2+LAT cycles after the previous layer's last,
    // write-back 1+LAT cycles after each fetch, iteration-end decision one
    // cycle after the last write-back, done the cycle after that decision.
    task automatic build_model(input int mi);
        int emax, t, last_rd, dec;
        for (int c = 0; c < NC; c++) begin
            exp_rd[c] = '0;
            exp_wr[c] = '0;
        end
        emax = (mi == 0) ? 1 : mi;
        t = 1; last_rd = 0;
        m_done = -1; m_early = 0; m_iter = 0;
        for (int it = 0; it < emax && m_done < 0; it++) begin
            for (int ly = 0; ly < NLAYER; ly++) begin
                for (int cl = 0; cl < NCOL; cl++) begin
                    while (hold_at[t]) t++;
                    exp_rd[t]         = {1'b1, LW'(ly), CW'(cl)};
                    exp_wr[t + 1 + LAT] = {1'b1, LW'(ly), CW'(cl)};
                    t++;
                end
                last_rd = t - 1;
                if (ly < NLAYER - 1) t = last_rd + 2 + LAT;
            end
            dec = last_rd + LAT + 2;
            m_iter = it;
            if (synd_at[dec]) begin
                m_done = dec + 1; m_early = 1;
            end else if (it == emax - 1) begin
                m_done = dec + 1;
            end else begin
                t = dec + 1;
            end
        end
    endtask

    task automatic run_case(input int mi, input bit busy_start,
                            output int a_done, output int a_early, output int a_iter,
                            output int a_rd, output int a_wr);
        int last_c;
        logic [TW-1:0] ar, aw;
        build_model(mi);
        a_done = -1; a_early = 0; a_iter = 0; a_rd = 0; a_wr = 0;
        last_c = (m_done > 0 && m_done + 3 < NC) ? m_done + 3 : NC - 1;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk); #1;
            start       = (c == 0) || (busy_start && c == 5);
            max_iter    = (c == 0) ? IW'(mi) : IW'($urandom);
            hold        = hold_at[c];
            syndrome_ok = synd_at[c];
            @(negedge clk);
            ar = rd_en ? {1'b1, rd_layer, rd_col} : '0;
            aw = wr_en ? {1'b1, wr_layer, wr_col} : '0;
            chk($sformatf("rd c%0d", c), 32'(ar), 32'(exp_rd[c]));
            chk($sformatf("wr c%0d", c), 32'(aw), 32'(exp_wr[c]));
            chk($sformatf("busy c%0d", c), 32'(busy), 32'((c >= 1 && c <= m_done) ? 1 : 0));
            chk($sformatf("done c%0d", c), 32'(done), 32'((c == m_done) ? 1 : 0));
            if (c == 1) chk("early cleared", 32'(early), 32'd0);
            if (rd_en) a_rd++;
            if (wr_en) a_wr++;
            if (done && a_done < 0) begin
                a_done = c; a_early = int'(early); a_iter = int'(iter);
            end
        end
        start = 1'b0; hold = 1'b0; syndrome_ok = 1'b0;
    endtask

    initial begin
        vec_t tbl [5];
        int ad, ae, ai, ar, aw;
        int mi, sf;
        //          mi hlo hhi synd bs  done early iter rd
        tbl[0] = '{1, -1, -1, -1, 1'b0, 16, 0, 0, 8};
        tbl[1] = '{1,  2,  3, -1, 1'b0, 18, 0, 0, 8};
        tbl[2] = '{3, -1, -1,  0, 1'b0, 16, 1, 0, 8};
        tbl[3] = '{3, -1, -1, -1, 1'b0, 46, 0, 2, 24};
        tbl[4] = '{0, -1, -1, -1, 1'b1, 16, 0, 0, 8};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outs", {rd_en, wr_en, busy, done, early, 27'd0},
            32'd0);
        chk("reset iter/col", {iter, rd_col, 22'd0}, 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            set_stim(tbl[k].hold_lo, tbl[k].hold_hi, tbl[k].synd_from);
            run_case(tbl[k].mi, tbl[k].busy_start, ad, ae, ai, ar, aw);
            chk($sformatf("vec%0d done cycle", k), ad, tbl[k].exp_done);
            chk($sformatf("vec%0d early", k), ae, tbl[k].exp_early);
            chk($sformatf("vec%0d iter", k), ai, tbl[k].exp_iter);
            chk($sformatf("vec%0d rd count", k), ar, tbl[k].exp_rd);
            chk($sformatf("vec%0d wr count", k), aw, tbl[k].exp_rd);
        end

        // Reset in the middle of a frame.
        set_stim(-1, -1, -1);
        @(posedge clk); #1; start = 1'b1; max_iter = IW'(1);
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre-reset wr_en c6", 32'(wr_en), 32'd1);
        #1; rst = 1'b1;
        #1;
        chk("async reset outs", {rd_en, wr_en, busy, done, early, iter, rd_col, wr_col, 17'd0}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("post-reset quiet c%0d", c), {wr_en, busy, done}, 32'd0);
        end
        run_case(1, 1'b0, ad, ae, ai, ar, aw);
        chk("post-reset done cycle", ad, 16);

        // Randomized frames against the schedule model.
        for (int k = 0; k < 6; k++) begin
            mi = int'($urandom_range(0, 4));
            sf = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 80)) : -1;
            for (int c = 0; c < NC; c++) begin
                hold_at[c] = (c >= 1) && (c < 100) && ($urandom_range(0, 3) == 0);
                synd_at[c] = (sf >= 0) && (c >= sf);
            end
            run_case(mi, 1'b0, ad, ae, ai, ar, aw);
            chk($sformatf("rand%0d done cycle", k), ad, m_done);
            chk($sformatf("rand%0d early", k), ae, m_early);
            chk($sformatf("rand%0d iter", k), ai, m_iter);
            chk($sformatf("rand%0d rd=wr count", k), ar, aw);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
